mrgp_rf_sequencer: RTL and testbench

- Controller for the 8 x 16-bit general-purpose register file. Drives its SRC, DST, D_IN, STO and RST pins.
- After reset, sequences a clear sweep that zeroes R0..R7, one register per cycle.
- Then round-robin arbitrates the single read/write port between two requesters: A (execute stage) and B (host/debug).
- Sits between the core's issue logic and the register file instance.

---
 rtl/mrgp_rf_pkg.sv | 31 +++
 rtl/mrgp_rf_sequencer_arb.sv | 42 ++++
 rtl/mrgp_rf_sequencer.sv | 156 +++++++++++++++
 tb/tb_mrgp_rf_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mrgp_rf_pkg.sv
// Shared types, constants and operand encoding for the register-file sequencer.
package mrgp_rf_pkg;

   typedef enum logic {
      SWEEP = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int NREG    = 8;
   localparam int IDX_W   = 3;
   localparam int IDX_LSB = 3;
   localparam int DATA_W  = 16;
   localparam logic [1:0] MODE_REG = 2'b00;

   typedef struct packed {
      logic              we;
      logic [IDX_W-1:0]  raddr;
      logic [IDX_W-1:0]  waddr;
      logic [DATA_W-1:0] wdata;
   } acc_t;

   // Register-direct operand: index at [IDX_LSB+2:IDX_LSB], mode bits [7:6], rest zero.
   function automatic logic [DATA_W-1:0] mk_operand(input logic [IDX_W-1:0] idx);
      logic [DATA_W-1:0] op;
      op = '0;
      op[7:6] = MODE_REG;
      op[IDX_LSB +: IDX_W] = idx;
      return op;
   endfunction

endpackage

// File: rtl/mrgp_rf_sequencer_arb.sv
// mrgp_rr_arb2: 2-way round-robin arbiter; a requester granted last cycle is masked out.
module mrgp_rr_arb2
   import mrgp_rf_pkg::*;
#(
   parameter logic PRIO_INIT = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   input  logic [1:0] gnt_last,
   output logic [1:0] win
);

   logic       rr_q;
   logic [1:0] elig;

   assign elig = req & ~gnt_last;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      win = 2'b00;
      if (en) begin
         case (elig)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = rr_q ? 2'b10 : 2'b01;
            default: win = 2'b00;
         endcase
      end
   end

   // rr only moves on a real contest; it then points at the loser.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q <= PRIO_INIT;
      end else if (en && elig == 2'b11) begin
         rr_q <= ~rr_q;
      end
   end

endmodule

// File: rtl/mrgp_rf_sequencer.sv
// mrgp_rf_sequencer: clear sweep of R0..R7 then round-robin access to the register-file port.
// Build option MRGP_RF_BYPASS_EN: same-index read+write returns the write data.
module mrgp_rf_sequencer
   import mrgp_rf_pkg::*;
#(
   parameter logic PRIO_INIT = 1'b0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLR_REQ,
   input  logic              A_REQ,
   input  logic              B_REQ,
   input  logic              A_WE,
   input  logic              B_WE,
   input  logic [IDX_W-1:0]  A_RADDR,
   input  logic [IDX_W-1:0]  B_RADDR,
   input  logic [IDX_W-1:0]  A_WADDR,
   input  logic [IDX_W-1:0]  B_WADDR,
   input  logic [DATA_W-1:0] A_WDATA,
   input  logic [DATA_W-1:0] B_WDATA,
   output logic              A_GNT,
   output logic              B_GNT,
   output logic              A_RVLD,
   output logic              B_RVLD,
   output logic [DATA_W-1:0] A_RDATA,
   output logic [DATA_W-1:0] B_RDATA,
   output logic [DATA_W-1:0] RF_SRC,
   output logic [DATA_W-1:0] RF_DST,
   output logic [DATA_W-1:0] RF_DIN,
   output logic              RF_STO,
   output logic              RF_CLR,
   input  logic [DATA_W-1:0] RF_DOUT,
   output logic              INIT_DONE
);

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
   logic [1:0]        win;
   logic              arb_en;
   acc_t              acc_a, acc_b, acc_sel;
   logic              a_gnt_d, b_gnt_d, sto_d, clr_d, init_done_d;
   logic [DATA_W-1:0] src_d, dst_d, din_d, rd_val;

   assign acc_a   = '{we: A_WE, raddr: A_RADDR, waddr: A_WADDR, wdata: A_WDATA};
   assign acc_b   = '{we: B_WE, raddr: B_RADDR, waddr: B_WADDR, wdata: B_WDATA};
   assign acc_sel = win[1] ? acc_b : acc_a;

   // A clear request suppresses new grants; the access already on the port still finishes.
   assign arb_en = (state_q == RUN) && !CLR_REQ;

   mrgp_rr_arb2 #(.PRIO_INIT(PRIO_INIT)) u_arb (
      .clk      (CLK),
      .rst      (RST),
      .en       (arb_en),
      .req      ({B_REQ, A_REQ}),
      .gnt_last ({B_GNT, A_GNT}),
      .win      (win)
   );

   always_comb begin
      state_d     = state_q;
      clr_idx_d   = clr_idx_q;
      a_gnt_d     = 1'b0;
      b_gnt_d     = 1'b0;
      sto_d       = 1'b0;
      clr_d       = 1'b0;
      init_done_d = 1'b0;
      src_d       = '0;
      dst_d       = '0;
      din_d       = '0;
      case (state_q)
         SWEEP: begin
            clr_d     = 1'b1;
            dst_d     = mk_operand(clr_idx_q);
            clr_idx_d = clr_idx_q + IDX_W'(1);
            if (clr_idx_q == IDX_W'(NREG - 1)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (CLR_REQ) begin
               state_d   = SWEEP;
               clr_idx_d = '0;
            end else begin
               init_done_d = 1'b1;
               a_gnt_d     = win[0];
               b_gnt_d     = win[1];
               if (win != 2'b00) begin
                  src_d = mk_operand(acc_sel.raddr);
                  dst_d = mk_operand(acc_sel.waddr);
                  din_d = acc_sel.wdata;
                  sto_d = acc_sel.we;
               end
            end
         end
         default: state_d = SWEEP;
      endcase
   end

`ifdef MRGP_RF_BYPASS_EN
   logic byp_q;

   // RF_DIN still carries the granted write data during the GNT cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         byp_q <= 1'b0;
      end else begin
         byp_q <= (a_gnt_d || b_gnt_d) && acc_sel.we && (acc_sel.raddr == acc_sel.waddr);
      end
   end

   assign rd_val = byp_q ? RF_DIN : RF_DOUT;
`else
   assign rd_val = RF_DOUT;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= SWEEP;
         clr_idx_q <= '0;
         A_GNT     <= 1'b0;
         B_GNT     <= 1'b0;
         A_RVLD    <= 1'b0;
         B_RVLD    <= 1'b0;
         A_RDATA   <= '0;
         B_RDATA   <= '0;
         RF_SRC    <= '0;
         RF_DST    <= '0;
         RF_DIN    <= '0;
         RF_STO    <= 1'b0;
         RF_CLR    <= 1'b0;
         INIT_DONE <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         A_GNT     <= a_gnt_d;
         B_GNT     <= b_gnt_d;
         RF_SRC    <= src_d;
         RF_DST    <= dst_d;
         RF_DIN    <= din_d;
         RF_STO    <= sto_d;
         RF_CLR    <= clr_d;
         INIT_DONE <= init_done_d;
         A_RVLD    <= A_GNT;
         B_RVLD    <= B_GNT;
         if (A_GNT) begin
            A_RDATA <= rd_val;
         end
         if (B_GNT) begin
            B_RDATA <= rd_val;
         end
      end
   end

endmodule

// File: tb/tb_mrgp_rf_sequencer.sv
// Directed + randomized bench for mrgp_rf_sequencer with a behavioural register file and shadow model.
module tb_mrgp_rf_sequencer;

   logic        CLK = 1'b0;
   logic        RST, CLR_REQ, A_REQ, B_REQ, A_WE, B_WE;
   logic [2:0]  A_RADDR, B_RADDR, A_WADDR, B_WADDR;
   logic [15:0] A_WDATA, B_WDATA;
   logic        A_GNT, B_GNT, A_RVLD, B_RVLD;
   logic [15:0] A_RDATA, B_RDATA, RF_SRC, RF_DST, RF_DIN, RF_DOUT;
   logic        RF_STO, RF_CLR, INIT_DONE;

   logic [15:0] rf  [8];
   logic [15:0] mdl [8];
   int total = 0;
   int bad   = 0;

   mrgp_rf_sequencer #(.PRIO_INIT(1'b0)) dut (
      .CLK(CLK), .RST(RST), .CLR_REQ(CLR_REQ),
      .A_REQ(A_REQ), .B_REQ(B_REQ), .A_WE(A_WE), .B_WE(B_WE),
      .A_RADDR(A_RADDR), .B_RADDR(B_RADDR), .A_WADDR(A_WADDR), .B_WADDR(B_WADDR),
      .A_WDATA(A_WDATA), .B_WDATA(B_WDATA),
      .A_GNT(A_GNT), .B_GNT(B_GNT), .A_RVLD(A_RVLD), .B_RVLD(B_RVLD),
      .A_RDATA(A_RDATA), .B_RDATA(B_RDATA),
      .RF_SRC(RF_SRC), .RF_DST(RF_DST), .RF_DIN(RF_DIN),
      .RF_STO(RF_STO), .RF_CLR(RF_CLR), .RF_DOUT(RF_DOUT), .INIT_DONE(INIT_DONE)
   );

   always #5 CLK = ~CLK;

   // Register file: combinational read from SRC, write (or clear) of DST on the clock.
   assign RF_DOUT = rf[RF_SRC[5:3]];
   always @(posedge CLK) begin
      if (RF_CLR) rf[RF_DST[5:3]] <= 16'h0000;
      else if (RF_STO) rf[RF_DST[5:3]] <= RF_DIN;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int r = 0; r < 8; r++) mdl[r] = 16'h0000;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_a_gnt"},   32'(A_GNT), 0);
      check({tag, "_b_gnt"},   32'(B_GNT), 0);
      check({tag, "_a_rvld"},  32'(A_RVLD), 0);
      check({tag, "_b_rvld"},  32'(B_RVLD), 0);
      check({tag, "_a_rdata"}, 32'(A_RDATA), 0);
      check({tag, "_b_rdata"}, 32'(B_RDATA), 0);
      check({tag, "_src"},     32'(RF_SRC), 0);
      check({tag, "_dst"},     32'(RF_DST), 0);
      check({tag, "_din"},     32'(RF_DIN), 0);
      check({tag, "_sto"},     32'(RF_STO), 0);
      check({tag, "_clr"},     32'(RF_CLR), 0);
      check({tag, "_init"},    32'(INIT_DONE), 0);
   endtask

   // Eight clear cycles, DST index 0..7, no grants, INIT_DONE low.
   task automatic sweep_check(input string tag);
      for (int k = 0; k < 8; k++) begin
         tick();
         check({tag, "_sw_clr"},  32'(RF_CLR), 1);
         check({tag, "_sw_sto"},  32'(RF_STO), 0);
         check({tag, "_sw_dst"},  32'(RF_DST), 32'(k * 8));
         check({tag, "_sw_init"}, 32'(INIT_DONE), 0);
         check({tag, "_sw_gnt"},  32'(A_GNT | B_GNT), 0);
      end
   endtask

   task automatic wait_gnt(input bit who, input string tag);
      int n = 0;
      while ((who ? B_GNT : A_GNT) !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_gnt"},       32'(who ? B_GNT : A_GNT), 1);
      check({tag, "_other_gnt"}, 32'(who ? A_GNT : B_GNT), 0);
   endtask

   // One access by a lone requester, checked against the shadow register model.
   task automatic access(input bit who, input logic we, input logic [2:0] ra,
                         input logic [2:0] wa, input logic [15:0] wd);
      logic [15:0] exp;
      string tag;
      tag = who ? "b" : "a";
      if (who) begin
         B_REQ = 1'b1; B_WE = we; B_RADDR = ra; B_WADDR = wa; B_WDATA = wd;
      end else begin
         A_REQ = 1'b1; A_WE = we; A_RADDR = ra; A_WADDR = wa; A_WDATA = wd;
      end
      wait_gnt(who, tag);
      if (who) B_REQ = 1'b0;
      else A_REQ = 1'b0;
      check({tag, "_rf_src"}, 32'(RF_SRC), 32'(ra) * 8);
      check({tag, "_rf_dst"}, 32'(RF_DST), 32'(wa) * 8);
      check({tag, "_rf_din"}, 32'(RF_DIN), 32'(wd));
      check({tag, "_rf_sto"}, 32'(RF_STO), 32'(we));
      check({tag, "_rf_clr"}, 32'(RF_CLR), 0);
      exp = mdl[ra];
`ifdef MRGP_RF_BYPASS_EN
      if (we && ra == wa) exp = wd;
`endif
      if (we) mdl[wa] = wd;
      tick();
      check({tag, "_rvld"},  32'(who ? B_RVLD : A_RVLD), 1);
      check({tag, "_rdata"}, 32'(who ? B_RDATA : A_RDATA), 32'(exp));
   endtask

   initial begin
      logic [15:0] exp, prev_exp;
      logic [2:0]  ra, wa;
      bit          who, prev_who;

      RST = 1'b1; CLR_REQ = 1'b0; A_REQ = 1'b0; B_REQ = 1'b0; A_WE = 1'b0; B_WE = 1'b0;
      A_RADDR = '0; B_RADDR = '0; A_WADDR = '0; B_WADDR = '0; A_WDATA = '0; B_WDATA = '0;
      tick();
      check_reset("por");
      RST = 1'b0;
      sweep_check("por");
      tick();
      check("por_init_done", 32'(INIT_DONE), 1);
      check("por_idle_clr",  32'(RF_CLR), 0);
      clear_model();

      // Preload every register with a nonzero value, then reset and confirm the sweep zeroes them.
      for (int r = 0; r < 8; r++) access(0, 1'b1, 3'(r), 3'(r), 16'($urandom_range(1, 16'hffff)));
      RST = 1'b1;
      tick();
      check_reset("rst2");
      RST = 1'b0;
      sweep_check("rst2");
      tick();
      check("rst2_init_done", 32'(INIT_DONE), 1);
      clear_model();
      access(0, 1'b0, 3'd5, 3'd0, 16'h0000);

      access(0, 1'b1, 3'd0, 3'd3, 16'hBEEF);
      access(0, 1'b0, 3'd3, 3'd0, 16'h0000);
      access(1, 1'b1, 3'd0, 3'd2, 16'h00AA);
      access(0, 1'b1, 3'd2, 3'd2, 16'h1234);

      for (int i = 0; i < 40; i++) begin
         ra = 3'($urandom_range(0, 7));
         wa = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
         access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, wa, 16'($urandom));
      end

      // Clear request in B's grant cycle while A is waiting.
      B_REQ = 1'b1; B_WE = 1'b0; B_RADDR = 3'($urandom_range(0, 7));
      exp = mdl[B_RADDR];
      wait_gnt(1, "clr_b");
      B_REQ = 1'b0; CLR_REQ = 1'b1;
      A_REQ = 1'b1; A_WE = 1'b0; A_RADDR = 3'($urandom_range(0, 7));
      check("clr_init_before", 32'(INIT_DONE), 1);
      tick();
      CLR_REQ = 1'b0;
      check("clr_b_rvld",    32'(B_RVLD), 1);
      check("clr_b_rdata",   32'(B_RDATA), 32'(exp));
      check("clr_init_drop", 32'(INIT_DONE), 0);
      check("clr_a_held",    32'(A_GNT), 0);
      check("clr_idle_clr",  32'(RF_CLR), 0);
      sweep_check("clr");
      clear_model();
      tick();
      check("clr_init_up", 32'(INIT_DONE), 1);
      check("clr_a_gnt",   32'(A_GNT), 1);
      A_REQ = 1'b0;
      tick();
      check("clr_a_rvld",  32'(A_RVLD), 1);
      check("clr_a_rdata", 32'(A_RDATA), 32'(mdl[A_RADDR]));

      // Reset while a grant is on the port: its RVLD must never appear.
      A_REQ = 1'b1; A_WE = 1'b0; A_RADDR = 3'($urandom_range(0, 7));
      wait_gnt(0, "rstf");
      A_REQ = 1'b0; RST = 1'b1;
      tick();
      check_reset("rstf");
      RST = 1'b0;
      clear_model();

      // Both requesters hold REQ through the sweep: grants alternate A, B, A, B...
      A_REQ = 1'b1; A_WE = 1'b1; A_RADDR = 3'd2; A_WADDR = 3'd1; A_WDATA = 16'($urandom);
      B_REQ = 1'b1; B_WE = 1'b1; B_RADDR = 3'd1; B_WADDR = 3'd2; B_WDATA = 16'($urandom);
      sweep_check("cont");
      prev_exp = '0;
      prev_who = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         who = 1'(i % 2);
         if (i == 0) check("cont_init_done", 32'(INIT_DONE), 1);
         check("cont_a_gnt", 32'(A_GNT), 32'(!who));
         check("cont_b_gnt", 32'(B_GNT), 32'(who));
         check("cont_sto_clr", 32'(RF_STO & RF_CLR), 0);
         if (i > 0) begin
            check("cont_rvld",  32'(prev_who ? B_RVLD : A_RVLD), 1);
            check("cont_rdata", 32'(prev_who ? B_RDATA : A_RDATA), 32'(prev_exp));
         end
         if (who) begin
            prev_exp = mdl[B_RADDR];
            mdl[B_WADDR] = B_WDATA;
         end else begin
            prev_exp = mdl[A_RADDR];
            mdl[A_WADDR] = A_WDATA;
         end
         prev_who = who;
         if (i == 5) begin
            A_REQ = 1'b0;
            B_REQ = 1'b0;
         end
      end
      tick();
      check("cont_last_rvld",  32'(B_RVLD), 1);
      check("cont_last_rdata", 32'(B_RDATA), 32'(prev_exp));
      check("cont_no_gnt",     32'(A_GNT | B_GNT), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
